// File: rtl/loba_pkg.sv
// Shared LOBA definitions: position-field width helper and the leading-one
// detector used by every segment extractor.
package loba_pkg;

  // Widest operand the leading-one detector handles.
  localparam int LOBA_MAX_N = 64;
  localparam int LOBA_POS_W = 7;

  typedef struct packed {
    logic                  found;  // operand had at least one set bit
    logic [LOBA_POS_W-1:0] pos;    // index of the most significant set bit
  } lead_one_t;

  // Width of a leading-one position field for an n-bit operand.
  function automatic int loba_kw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Most significant set bit of v; found = 0 for a zero operand.
  function automatic lead_one_t lead_one(input logic [LOBA_MAX_N-1:0] v);
    lead_one_t r;
    r = '0;
    for (int i = 0; i < LOBA_MAX_N; i++) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.pos   = LOBA_POS_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/loba_seg_stage.sv
// One segment extractor plus its pipeline register. Earlier segments ride
// along in the mant/k/seg buses: each stage shifts them down one slot and
// inserts its own segment in the top slot, so after S stages segment s sits
// in slot s.
module loba_seg_stage
  import loba_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 4,
  parameter int S     = 2,
  parameter bit FIRST = 1'b0,
  parameter int KW    = loba_kw(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            vld_in,
  input  logic [N-1:0]    res_in,
  input  logic            exact_in,
  input  logic [S*W-1:0]  mant_in,
  input  logic [S*KW-1:0] k_in,
  input  logic [S-1:0]    seg_in,
  output logic            vld_q,
  output logic [N-1:0]    res_q,
  output logic            exact_q,
  output logic [S*W-1:0]  mant_q,
  output logic [S*KW-1:0] k_q,
  output logic [S-1:0]    seg_q
);

  localparam int MW = S * W;
  localparam int KB = S * KW;

  lead_one_t    lo;
  int           p;
  int           sh;
  logic [W-1:0] mant;
  logic [KW-1:0] k;
  logic         seg;
  logic [N-1:0] rest;
  logic [N-1:0] contrib;
  logic [N-1:0] dropped;

  // Extract this segment from the incoming residual and form the next residual.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    lo   = lead_one(LOBA_MAX_N'(res_in));
    p    = int'(lo.pos);
    sh   = 0;
    mant = '0;
    k    = '0;
    seg  = 1'b0;
    rest = '0;
    if (lo.found && p >= W - 1) begin
      sh   = p - W + 1;
      mant = W'(res_in >> sh);
      k    = KW'(p);
      seg  = 1'b1;
      // Only bits strictly below the mantissa window survive, and only when a
      // full window's worth of them exists.
      if (p >= 2 * W - 1) rest = res_in & ((N'(1) << sh) - N'(1));
    end else if (FIRST) begin
      // Small or zero operand: the bottom W bits stand for it unshifted.
      mant = res_in[W-1:0];
      k    = KW'(W - 1);
      seg  = 1'b1;
    end
    contrib = N'(mant) << sh;
    // Bits neither captured by this segment nor passed on are lost for good.
    dropped = res_in & ~contrib & ~rest;
  end

  // Pipeline register: load when enabled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset as well as the valid bit, so the result
    // buses read zero while reset is held.
    if (!rst_n) begin
      vld_q   <= 1'b0;
      res_q   <= '0;
      exact_q <= 1'b0;
      mant_q  <= '0;
      k_q     <= '0;
      seg_q   <= '0;
    end else if (en) begin
      // NOTE: state is updated with non-blocking assignments so every stage
      // samples its neighbour's value from before the edge.
      vld_q   <= vld_in;
      res_q   <= rest;
      exact_q <= exact_in & ~|dropped;
      mant_q  <= (mant_in >> W) | (MW'(mant) << ((S - 1) * W));
      k_q     <= (k_in >> KW) | (KB'(k) << ((S - 1) * KW));
      seg_q   <= (seg_in >> 1) | (S'(seg) << (S - 1));
    end
  end

endmodule

// File: rtl/loba_split_pipe.sv
// LOBA operand splitter: S pipelined segment extractors behind a
// valid/ready handshake with per-stage bubble collapsing.
module loba_split_pipe
  import loba_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4,
  parameter int S = 2,
  localparam int KW = loba_kw(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [S*W-1:0]  out_mant,
  output logic [S*KW-1:0] out_k,
  output logic [S-1:0]    out_seg_vld,
  output logic            out_exact
);

  if (W < 2 || S < 1 || S * W > N || N > LOBA_MAX_N) begin : g_bad_params
    $error("loba_split_pipe: illegal parameters N=%0d W=%0d S=%0d", N, W, S);
  end

  // Index 0 is the input side; index s+1 is the register of stage s.
  logic [S:0]               vld;
  logic [S:0][N-1:0]        res;
  logic [S:0]               exact;
  logic [S:0][S*W-1:0]      mant;
  logic [S:0][S*KW-1:0]     kb;
  logic [S:0][S-1:0]        seg;
  logic [S-1:0]             en;
  logic                     go;

  assign vld[0]   = in_valid;
  assign res[0]   = in_data;
  assign exact[0] = 1'b1;
  assign mant[0]  = '0;
  assign kb[0]    = '0;
  assign seg[0]   = '0;

  // Stage s may load when the consumer drains or any register from s onward
  // is empty; written flat rather than as a ripple through en.
  always_comb begin
    en = '0;
    go = 1'b0;
    for (int s = 0; s < S; s++) begin
      go = out_ready;
      for (int j = s; j < S; j++) go = go | ~vld[j+1];
      en[s] = go;
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    loba_seg_stage #(
      .N    (N),
      .W    (W),
      .S    (S),
      .FIRST(s == 0),
      .KW   (KW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[s]),
      .vld_in  (vld[s]),
      .res_in  (res[s]),
      .exact_in(exact[s]),
      .mant_in (mant[s]),
      .k_in    (kb[s]),
      .seg_in  (seg[s]),
      .vld_q   (vld[s+1]),
      .res_q   (res[s+1]),
      .exact_q (exact[s+1]),
      .mant_q  (mant[s+1]),
      .k_q     (kb[s+1]),
      .seg_q   (seg[s+1])
    );
  end

  assign in_ready    = en[0];
  assign out_valid   = vld[S];
  assign out_mant    = mant[S];
  assign out_k       = kb[S];
  assign out_seg_vld = seg[S];
  // Exact only if nothing was dropped along the way and no residual remains.
  assign out_exact   = exact[S] & ~|res[S];

endmodule
